// File: rtl/lt24_lcd_bus_decoder.sv
// Panel-side decoder for the LT24 8080-style 16-bit write bus: turns WRX strobes into
// decoded commands and addressed pixel writes, tracking the CASET/PASET window like the panel.
module lt24_lcd_bus_decoder #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tft_rst,
  input  logic        tft_csx,
  input  logic        tft_dcx,
  input  logic        tft_wrx,
  input  logic        tft_rdx,
  input  logic [15:0] tft_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pixel_valid,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic [15:0] pixel_rgb,
  output logic        sleep_out,
  output logic        display_on,
  output logic        protocol_error
);

  localparam logic [15:0] EC_RST = 16'(H_RES - 1);
  localparam logic [15:0] EP_RST = 16'(V_RES - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_PASET_P,
    ST_RAMWR
  } state_t;

  logic        rst_any;
  assign rst_any = reset | ~tft_rst;

  // Bus sampling registers
  logic        wrx_q, wrx_d;
  logic        csx_q, csx_d;
  logic        dcx_q, dcx_d;
  logic [15:0] data_q, data_d;
  logic        blk_q, blk_d;

  // Decoder state
  state_t      state_q, state_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [23:0] pbuf_q, pbuf_d;
  logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [15:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

  // Registered outputs
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [15:0] pixel_x_q, pixel_x_d;
  logic [15:0] pixel_y_q, pixel_y_d;
  logic [15:0] pixel_rgb_q, pixel_rgb_d;
  logic        sleep_q, sleep_d;
  logic        disp_q, disp_d;
  logic        perr_q, perr_d;

  logic        wr_rise, accept, rd_conflict;
  logic [15:0] new_start, new_end;

  always_comb begin
    wrx_d         = tft_wrx;
    csx_d         = tft_csx;
    dcx_d         = tft_dcx;
    data_d        = tft_data;
    blk_d         = blk_q;
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    pbuf_d        = pbuf_q;
    sc_d          = sc_q;
    ec_d          = ec_q;
    sp_d          = sp_q;
    ep_d          = ep_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    pixel_rgb_d   = pixel_rgb_q;
    sleep_d       = sleep_q;
    disp_d        = disp_q;
    new_start     = pbuf_q[23:8];
    new_end       = {pbuf_q[7:0], data_q[7:0]};

    rd_conflict = ~tft_csx & ~tft_rdx & ~tft_wrx;
    perr_d      = rd_conflict;
    wr_rise     = tft_wrx & ~wrx_q;
    accept      = wr_rise & ~csx_q & ~blk_q;

    // A read/write clash poisons the strobe in progress until its rising edge.
    if (rd_conflict) begin
      blk_d = 1'b1;
    end else if (wr_rise) begin
      blk_d = 1'b0;
    end

    if (accept) begin
      if (!dcx_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = data_q[7:0];
        pcnt_d      = 2'd0;
        state_d     = ST_IDLE;
        case (data_q[7:0])
          CMD_SWRESET: begin
            sc_d    = 16'd0;
            ec_d    = EC_RST;
            sp_d    = 16'd0;
            ep_d    = EP_RST;
            sleep_d = 1'b0;
            disp_d  = 1'b0;
          end
          CMD_SLPIN:   sleep_d = 1'b0;
          CMD_SLPOUT:  sleep_d = 1'b1;
          CMD_DISPOFF: disp_d  = 1'b0;
          CMD_DISPON:  disp_d  = 1'b1;
          CMD_CASET:   state_d = ST_CASET_P;
          CMD_PASET:   state_d = ST_PASET_P;
          CMD_RAMWR: begin
            cur_x_d = sc_q;
            cur_y_d = sp_q;
            state_d = ST_RAMWR;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_CASET_P, ST_PASET_P: begin
            if (pcnt_q == 2'd3) begin
              state_d = ST_IDLE;
              pcnt_d  = 2'd0;
              if (state_q == ST_CASET_P) begin
                if (new_start <= new_end && new_end <= EC_RST) begin
                  sc_d = new_start;
                  ec_d = new_end;
                end else begin
                  perr_d = 1'b1;
                end
              end else begin
                if (new_start <= new_end && new_end <= EP_RST) begin
                  sp_d = new_start;
                  ep_d = new_end;
                end else begin
                  perr_d = 1'b1;
                end
              end
            end else begin
              pbuf_d = {pbuf_q[15:0], data_q[7:0]};
              pcnt_d = 2'(pcnt_q + 2'd1);
            end
          end
          ST_RAMWR: begin
            pixel_valid_d = 1'b1;
            pixel_x_d     = cur_x_q;
            pixel_y_d     = cur_y_q;
            pixel_rgb_d   = data_q;
            // Raster order inside the window, wrapping back to its top-left corner.
            if (cur_x_q == ec_q) begin
              cur_x_d = sc_q;
              cur_y_d = (cur_y_q == ep_q) ? sp_q : cur_y_q + 16'd1;
            end else begin
              cur_x_d = cur_x_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      wrx_q         <= 1'b1;
      csx_q         <= 1'b1;
      dcx_q         <= 1'b1;
      data_q        <= 16'd0;
      blk_q         <= 1'b0;
      state_q       <= ST_IDLE;
      pcnt_q        <= 2'd0;
      pbuf_q        <= 24'd0;
      sc_q          <= 16'd0;
      ec_q          <= EC_RST;
      sp_q          <= 16'd0;
      ep_q          <= EP_RST;
      cur_x_q       <= 16'd0;
      cur_y_q       <= 16'd0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'd0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= 16'd0;
      pixel_y_q     <= 16'd0;
      pixel_rgb_q   <= 16'd0;
      sleep_q       <= 1'b0;
      disp_q        <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      wrx_q         <= wrx_d;
      csx_q         <= csx_d;
      dcx_q         <= dcx_d;
      data_q        <= data_d;
      blk_q         <= blk_d;
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      pbuf_q        <= pbuf_d;
      sc_q          <= sc_d;
      ec_q          <= ec_d;
      sp_q          <= sp_d;
      ep_q          <= ep_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_rgb_q   <= pixel_rgb_d;
      sleep_q       <= sleep_d;
      disp_q        <= disp_d;
      perr_q        <= perr_d;
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_code       = cmd_code_q;
  assign pixel_valid    = pixel_valid_q;
  assign pixel_x        = pixel_x_q;
  assign pixel_y        = pixel_y_q;
  assign pixel_rgb      = pixel_rgb_q;
  assign sleep_out      = sleep_q;
  assign display_on     = disp_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_lt24_lcd_bus_decoder.sv
// Scoreboard bench for lt24_lcd_bus_decoder: a window/cursor model predicts commands,
// pixels and protocol errors; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_lt24_lcd_bus_decoder;
  localparam int H_RES = 240;
  localparam int V_RES = 320;

  logic        clk = 1'b0;
  logic        reset, tft_rst, tft_csx, tft_dcx, tft_wrx, tft_rdx;
  logic [15:0] tft_data;
  logic        cmd_valid, pixel_valid, sleep_out, display_on, protocol_error;
  logic [7:0]  cmd_code;
  logic [15:0] pixel_x, pixel_y, pixel_rgb;

  lt24_lcd_bus_decoder #(.H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .reset(reset), .tft_rst(tft_rst), .tft_csx(tft_csx), .tft_dcx(tft_dcx),
    .tft_wrx(tft_wrx), .tft_rdx(tft_rdx), .tft_data(tft_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .sleep_out(sleep_out), .display_on(display_on), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [47:0] pix_exp[$];
  logic [9:0]  cmd_exp[$];
  bit          perr_exp[$];

  // Reference model: panel window, write cursor and what the controller is collecting.
  int m_mode;               // 0 idle, 1 column params, 2 page params, 3 pixel write
  int m_cnt;
  int m_pb[4];
  int m_sc, m_ec, m_sp, m_ep, m_cx, m_cy;
  bit m_slp, m_dsp;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0;
    m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1;
    m_cx = 0; m_cy = 0; m_slp = 0; m_dsp = 0;
  endtask

  task automatic model_word(input bit dc, input logic [15:0] d);
    int s, e, lim;
    if (!dc) begin
      m_mode = 0; m_cnt = 0;
      case (d[7:0])
        8'h01: begin
          m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1; m_slp = 0; m_dsp = 0;
        end
        8'h10: m_slp = 0;
        8'h11: m_slp = 1;
        8'h28: m_dsp = 0;
        8'h29: m_dsp = 1;
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_cx = m_sc; m_cy = m_sp; m_mode = 3; end
        default: ;
      endcase
      cmd_exp.push_back({m_slp, m_dsp, d[7:0]});
    end else if (m_mode == 1 || m_mode == 2) begin
      m_pb[m_cnt] = int'(d[7:0]);
      m_cnt++;
      if (m_cnt == 4) begin
        s = m_pb[0] * 256 + m_pb[1];
        e = m_pb[2] * 256 + m_pb[3];
        lim = (m_mode == 1) ? H_RES : V_RES;
        if (s <= e && e < lim) begin
          if (m_mode == 1) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end else begin
          perr_exp.push_back(1'b1);
        end
        m_mode = 0; m_cnt = 0;
      end
    end else if (m_mode == 3) begin
      pix_exp.push_back({16'(m_cx), 16'(m_cy), d});
      if (m_cx == m_ec) begin
        m_cx = m_sc;
        m_cy = (m_cy == m_ep) ? m_sp : m_cy + 1;
      end else begin
        m_cx = m_cx + 1;
      end
    end
  endtask

  // One bus write: WRX low for a cycle, then high; the rising edge is seen one clock later.
  task automatic wr(input bit dc, input logic [15:0] d, input bit sel = 1'b1);
    @(posedge clk); #1;
    tft_csx = ~sel; tft_dcx = dc; tft_data = d; tft_wrx = 1'b0;
    @(posedge clk); #1;
    tft_wrx = 1'b1;
    if (sel) model_word(dc, d);
  endtask

  task automatic idle_bus(input int n);
    @(posedge clk); #1;
    tft_csx = 1'b1; tft_wrx = 1'b1; tft_rdx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic conflict_write(input logic [15:0] d);
    @(posedge clk); #1;
    tft_csx = 1'b0; tft_dcx = 1'b1; tft_data = d; tft_wrx = 1'b0; tft_rdx = 1'b0;
    perr_exp.push_back(1'b1);
    @(posedge clk); #1;
    tft_rdx = 1'b1; tft_wrx = 1'b1;
  endtask

  task automatic win(input logic [7:0] cmd, input int s, input int e);
    wr(1'b0, {8'h00, cmd});
    wr(1'b1, {8'($urandom), 8'(s >> 8)});
    wr(1'b1, {8'($urandom), 8'(s)});
    wr(1'b1, {8'($urandom), 8'(e >> 8)});
    wr(1'b1, {8'($urandom), 8'(e)});
  endtask

  task automatic do_reset(input bit use_tft_rst);
    idle_bus(2);
    @(posedge clk); #1;
    if (use_tft_rst) tft_rst = 1'b0; else reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tft_rst = 1'b1; reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_cmd_valid"}, 48'(cmd_valid), 48'd0);
    chk({tag, "_cmd_code"}, 48'(cmd_code), 48'd0);
    chk({tag, "_pixel_valid"}, 48'(pixel_valid), 48'd0);
    chk({tag, "_pixel_xyrgb"}, {pixel_x, pixel_y, pixel_rgb}, 48'd0);
    chk({tag, "_sleep_out"}, 48'(sleep_out), 48'd0);
    chk({tag, "_display_on"}, 48'(display_on), 48'd0);
    chk({tag, "_protocol_error"}, 48'(protocol_error), 48'd0);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && tft_rst) begin
      if (pixel_valid) begin
        if (pix_exp.size() == 0) chk("unexpected_pixel", 48'(pixel_valid), 48'd0);
        else chk("pixel_xy_rgb", {pixel_x, pixel_y, pixel_rgb}, pix_exp.pop_front());
      end
      if (cmd_valid) begin
        if (cmd_exp.size() == 0) chk("unexpected_cmd", 48'(cmd_valid), 48'd0);
        else chk("cmd_sleep_disp_code", {38'd0, sleep_out, display_on, cmd_code}, 48'(cmd_exp.pop_front()));
      end
      if (protocol_error) begin
        if (perr_exp.size() == 0) chk("unexpected_protocol_error", 48'(protocol_error), 48'd0);
        else chk("protocol_error", 48'(protocol_error), 48'(perr_exp.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmds[11];
    int n, r;
    cmds = '{8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h00, 8'h36, 8'h3A};
    reset = 1'b1; tft_rst = 1'b1; tft_csx = 1'b1; tft_dcx = 1'b1;
    tft_wrx = 1'b1; tft_rdx = 1'b1; tft_data = 16'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_bus(3);
    check_reset_state("reset");

    wr(1'b0, 16'h0011);
    wr(1'b0, 16'h0029);
    wr(1'b0, 16'h0010);
    idle_bus(2);
    @(negedge clk);
    chk("cmd_code_held", 48'(cmd_code), 48'h10);
    chk("display_on_held", 48'(display_on), 48'd1);

    do_reset(1'b1);
    check_reset_state("tft_rst");

    win(8'h2A, 0, 1);
    win(8'h2B, 0, 1);
    wr(1'b0, 16'h002C);
    for (int i = 0; i < 5; i++) wr(1'b1, 16'hF800 + 16'(i));

    win(8'h2A, 5, 2);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'h1234);

    wr(1'b1, 16'hAAAA, 1'b0);
    wr(1'b0, 16'h0000);
    wr(1'b1, 16'h5555);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'h0BAD, 1'b0);
    wr(1'b1, 16'h7777);
    conflict_write(16'hDEAD);
    wr(1'b1, 16'h8888);
    wr(1'b0, 16'h0036);
    wr(1'b1, 16'h9999);

    win(8'h2A, 10, 20);
    wr(1'b0, 16'h002C);
    for (int i = 0; i < 3; i++) wr(1'b1, 16'h4000 + 16'(i));
    do_reset(1'b0);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'hC0DE);
    wr(1'b1, 16'hC0DF);

    win(8'h2A, 238, 239);
    win(8'h2B, 318, 319);
    win(8'h2B, 300, 320);
    wr(1'b0, 16'h002C);
    for (int i = 0; i < 5; i++) wr(1'b1, 16'(i * 3));

    for (int op = 0; op < 250; op++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 9: wr(1'b0, {8'($urandom), cmds[$urandom_range(0, 10)]});
        1, 2: win((r == 1) ? 8'h2A : 8'h2B,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 12),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 15));
        3: begin
          wr(1'b0, 16'h002C);
          n = $urandom_range(1, 12);
          for (int i = 0; i < n; i++) wr(1'b1, 16'($urandom));
        end
        4: begin
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) wr(1'b1, 16'($urandom), ($urandom_range(0, 3) != 0));
        end
        5: begin
          wr(1'b0, ($urandom_range(0, 1) == 1) ? 16'h002A : 16'h002B);
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) wr(1'b1, 16'($urandom_range(0, 3)));
        end
        6: conflict_write(16'($urandom));
        7: idle_bus($urandom_range(1, 4));
        default: if ($urandom_range(0, 5) == 0) do_reset($urandom_range(0, 1) == 1);
      endcase
    end

    idle_bus(4);
    @(negedge clk);
    chk("pixels_outstanding", 48'(pix_exp.size()), 48'd0);
    chk("cmds_outstanding", 48'(cmd_exp.size()), 48'd0);
    chk("perr_outstanding", 48'(perr_exp.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
